vga_sync_gen: RTL and testbench

Raster timing generator for the DE2-115 VGA path. It produces the `counterX`/`counterY` pixel coordinates consumed by the per-object renderers (paddles, snake segments, characters), and the `hsync_n`, `vsync_n` and `blank_n` strobes driven to the ADV7123 DAC. It sits between the board clock and the renderer/colour-mux stage. Every coordinate and strobe it emits is registered and aligned to the same pixel.

---
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the DE2-115 VGA path.
// Emits registered pixel coordinates plus sync/blank strobes, all pixel-aligned.
//
// Ports:
//   clk          in   board clock
//   reset_n      in   synchronous active-low reset
//   counterX     out  current pixel column, 0..H_TOTAL-1
//   counterY     out  current line, 0..V_TOTAL-1
//   hsync_n      out  horizontal sync, active low
//   vsync_n      out  vertical sync, active low
//   blank_n      out  high only inside the visible region
//   pix_stb      out  one-clk pulse when new coordinates first appear
//   line_start   out  pix_stb qualified with counterX == 0
//   frame_start  out  pix_stb qualified with (counterX, counterY) == (0, 0)

module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [11:0] counterX,
    output logic [11:0] counterY,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic        pix_stb,
    output logic        line_start,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_LAST  = H_TOTAL - 12'd1;
    localparam logic [11:0] V_LAST  = V_TOTAL - 12'd1;

    localparam logic [11:0] H_VIS   = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [11:0]      r_x;
    logic [11:0]      r_y;
    logic             r_hs_n;
    logic             r_vs_n;
    logic             r_blank_n;
    logic             r_pix_stb;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_tick;
    logic [DIV_W-1:0] w_div_nxt;
    logic [11:0]      w_x_nxt;
    logic [11:0]      w_y_nxt;
    logic             w_hs_n_nxt;
    logic             w_vs_n_nxt;
    logic             w_blank_n_nxt;

    assign w_tick = (r_div == DIV_LAST);

    // Strobes are derived from the coordinates about to be loaded, so the
    // registered strobes always describe the pixel the counters show.
    always_comb begin
        w_div_nxt = r_div + 1'b1;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        if (w_tick) begin
            w_div_nxt = '0;
            if (r_x == H_LAST) begin
                w_x_nxt = 12'd0;
                w_y_nxt = (r_y == V_LAST) ? 12'd0 : r_y + 12'd1;
            end else begin
                w_x_nxt = r_x + 12'd1;
            end
        end
        w_blank_n_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
        w_hs_n_nxt    = !((w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END));
        w_vs_n_nxt    = !((w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END));
    end

    // Reset parks the raster on the last pixel of a frame, so the first
    // tick afterwards presents (0,0) together with frame_start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_hs_n        <= 1'b1;
            r_vs_n        <= 1'b1;
            r_blank_n     <= 1'b0;
            r_pix_stb     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hs_n        <= w_hs_n_nxt;
            r_vs_n        <= w_vs_n_nxt;
            r_blank_n     <= w_blank_n_nxt;
            r_pix_stb     <= w_tick;
            r_line_start  <= w_tick && (w_x_nxt == 12'd0);
            r_frame_start <= w_tick && (w_x_nxt == 12'd0)
                                    && (w_y_nxt == 12'd0);
        end
    end

    assign counterX    = r_x;
    assign counterY    = r_y;
    assign hsync_n     = r_hs_n;
    assign vsync_n     = r_vs_n;
    assign blank_n     = r_blank_n;
    assign pix_stb     = r_pix_stb;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen with three configurations.
// A driver predicts every edge from pixel arithmetic; a monitor pops and compares.

module tb_vga_sync_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ps;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic [11:0] cx    [3];
    logic [11:0] cy    [3];
    logic        hs    [3];
    logic        vs    [3];
    logic        bl    [3];
    logic        ps    [3];
    logic        ls    [3];
    logic        fs    [3];

    int checks = 0;
    int errors = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    // DUT 0: CLK_DIV=2, small raster 33x19
    vga_sync_gen #(
        .CLK_DIV(2),
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]),
        .counterX(cx[0]), .counterY(cy[0]),
        .hsync_n(hs[0]), .vsync_n(vs[0]), .blank_n(bl[0]),
        .pix_stb(ps[0]), .line_start(ls[0]), .frame_start(fs[0])
    );

    // DUT 1: CLK_DIV=1, raster 14x7
    vga_sync_gen #(
        .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]),
        .counterX(cx[1]), .counterY(cy[1]),
        .hsync_n(hs[1]), .vsync_n(vs[1]), .blank_n(bl[1]),
        .pix_stb(ps[1]), .line_start(ls[1]), .frame_start(fs[1])
    );

    // DUT 2: default 640x480 timing, first few lines only
    vga_sync_gen u_dut2 (
        .clk(clk), .reset_n(rst_n[2]),
        .counterX(cx[2]), .counterY(cy[2]),
        .hsync_n(hs[2]), .vsync_n(vs[2]), .blank_n(bl[2]),
        .pix_stb(ps[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    // k = number of edges with reset released since the last reset edge.
    // Pixel n = k/div has been presented; the reset state is pixel -1,
    // i.e. the last pixel of the frame.
    function automatic obs_t model(input int k, input int div,
                                   input int ha, input int hf,
                                   input int hsw, input int hb,
                                   input int va, input int vf,
                                   input int vsw, input int vb);
        obs_t o;
        int ht, vt, n, p, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = k / div;
        p  = (n + ht * vt - 1) % (ht * vt);
        x  = p % ht;
        y  = p / ht;
        o.x  = 12'(x);
        o.y  = 12'(y);
        o.bl = (x < ha) && (y < va);
        o.hs = !((x >= ha + hf) && (x < ha + hf + hsw));
        o.vs = !((y >= va + vf) && (y < va + vf + vsw));
        o.ps = (k > 0) && (k % div == 0);
        o.ls = o.ps && (x == 0);
        o.fs = o.ps && (x == 0) && (y == 0);
        return o;
    endfunction

    function automatic obs_t predict(input int d, input int k);
        obs_t o;
        case (d)
            0:       o = model(k, 2, 20, 4, 6, 3, 12, 2, 2, 3);
            1:       o = model(k, 1, 8, 2, 2, 2, 4, 1, 1, 1);
            default: o = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
        endcase
        return o;
    endfunction

    function automatic obs_t sample(input int d);
        obs_t o;
        o.x  = cx[d];
        o.y  = cy[d];
        o.hs = hs[d];
        o.vs = vs[d];
        o.bl = bl[d];
        o.ps = ps[d];
        o.ls = ls[d];
        o.fs = fs[d];
        return o;
    endfunction

    task automatic compare(input int d, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d t=%0t got x=%0d y=%0d hs=%b vs=%b bl=%b ps=%b ls=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b bl=%b ps=%b ls=%b fs=%b",
                     d, $time, a.x, a.y, a.hs, a.vs, a.bl, a.ps, a.ls, a.fs,
                     e.x, e.y, e.hs, e.vs, e.bl, e.ps, e.ls, e.fs);
        end
    endtask

    // Monitor: samples 1 time unit after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) compare(0, sample(0), q0.pop_front());
            if (q1.size() > 0) compare(1, sample(1), q1.pop_front());
            if (q2.size() > 0) compare(2, sample(2), q2.pop_front());
        end
    end

    int k    [3];
    int left [3];

    // Driver: sets reset for the coming edge and pushes the prediction.
    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            k[d]     = 0;
            left[d]  = 3;
        end
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (left[d] > 0) begin
                    rst_n[d] = 1'b0;
                    left[d]--;
                end else if (d < 2 && $urandom_range(0, 399) == 0) begin
                    rst_n[d] = 1'b0;
                    left[d]  = int'($urandom_range(0, 2));
                end else begin
                    rst_n[d] = 1'b1;
                end
                k[d] = rst_n[d] ? k[d] + 1 : 0;
                case (d)
                    0:       q0.push_back(predict(0, k[0]));
                    1:       q1.push_back(predict(1, k[1]));
                    default: q2.push_back(predict(2, k[2]));
                endcase
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
